io_controller: RTL

IO_CONTROLLER -- requirements
Module: io_controller

---
 rtl/io_pkg.sv | 15 +
 rtl/io_controller_key_debouncer.sv | 58 +++++
 rtl/io_controller.sv | 91 +++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O controller: data width, debounce default and FSM encoding.
package io_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned SW_W_DEFAULT     = 10;
  localparam int unsigned DEBOUNCE_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_DONE         = 2'd3
  } io_state_e;

endpackage

// File: rtl/io_controller_key_debouncer.sv
// Confirm-key conditioning: 2-flop synchronizer, consecutive-cycle debounce and press pulse.
module key_debouncer
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             key_sync;

  assign key_sync = sync_q[1];

  // The counter tracks consecutive cycles of disagreement and clears on
  // agreement or on acceptance, so it tops out at the threshold and never wraps.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (key_sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = key_sync;
        press_d = ~key_sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign pressed_o = ~level_q;
  assign press_o   = press_q;

endmodule

// File: rtl/io_controller.sv
// CPU I/O instruction handler: display writes complete at once, switch reads stall until key confirm.
module io_controller
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned SW_WIDTH        = SW_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                io_en,
  input  logic                io_sel,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                key_n,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                stall,
  output logic [DATA_W-1:0]   display_value,
  output logic                waiting
);

  io_state_e           state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic                key_pressed;
  logic                key_press;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk      (clk),
    .rst      (rst),
    .key_n_i  (key_n),
    .pressed_o(key_pressed),
    .press_o  (key_press)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    disp_d  = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (io_en && io_sel) begin
          state_d = ST_WAIT_PRESS;
        end else if (io_en) begin
          disp_d = cpu_wdata;
        end
      end
      ST_WAIT_PRESS: begin
        if (key_press) begin
          rdata_d = DATA_W'(sw_sync_q);
          state_d = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!key_pressed) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rdata_q   <= '0;
      disp_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      disp_q    <= disp_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Busy states are masked during reset so the pipeline is released at once;
  // a fresh read request in IDLE still stalls.
  assign stall   = ((state_q == ST_IDLE) && io_en && io_sel) ||
                   (!rst && ((state_q == ST_WAIT_PRESS) || (state_q == ST_WAIT_RELEASE)));
  assign waiting = !rst && (state_q == ST_WAIT_PRESS);

  assign cpu_rdata     = rdata_q;
  assign display_value = disp_q;

endmodule
